// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: walks i/j/k, drives A/B read
// addresses and MAC strobes with one cycle of read latency.
module matmul_ctrl #(
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_matrices_loaded,
  input  logic [K_BITS-1:0]      i_k,
  input  logic                   i_out_stall,
  output logic [A_ADDR_BITS-1:0] o_a_read_addr,
  output logic [B_ADDR_BITS-1:0] o_b_read_addr,
  output logic                   o_mac_en,
  output logic                   o_mac_first,
  output logic                   o_mac_last,
  output logic                   o_busy,
  output logic                   o_compute_finished
);

  localparam int I_BITS = $clog2(M + 1);
  localparam int J_BITS = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t                 r_state;
  logic [K_BITS-1:0]      r_kreg;
  logic [I_BITS-1:0]      r_i;
  logic [J_BITS-1:0]      r_j;
  logic [K_BITS-1:0]      r_k;
  logic [A_ADDR_BITS-1:0] r_a_base;
  logic [A_ADDR_BITS-1:0] r_a_addr;
  logic [B_ADDR_BITS-1:0] r_b_addr;
  logic                   r_mac_en;
  logic                   r_mac_first;
  logic                   r_mac_last;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_k0;
  logic                   w_klast;
  logic                   w_jlast;
  logic                   w_ilast;
  logic                   w_issue;
  logic [K_BITS-1:0]      w_ksat;
  logic [A_ADDR_BITS-1:0] w_kext;

  // Loop-end flags, issue qualification and K saturation
  always_comb begin
    w_k0    = (r_k == '0);
    w_klast = (r_k == r_kreg - K_BITS'(1));
    w_jlast = (r_j == J_BITS'(N - 1));
    w_ilast = (r_i == I_BITS'(M - 1));
    w_issue = (r_state == S_RUN) && !(w_k0 && i_out_stall);
    w_ksat  = (i_k > K_BITS'(MAXK)) ? K_BITS'(MAXK) : i_k;
    w_kext  = A_ADDR_BITS'(r_kreg);
  end

  // Sequencer FSM, counters, running address bases and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_kreg      <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_a_base    <= '0;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_mac_en    <= 1'b0;
      r_mac_first <= 1'b0;
      r_mac_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mac_en    <= w_issue;
      r_mac_first <= w_issue && w_k0;
      r_mac_last  <= w_issue && w_klast;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_matrices_loaded) begin
            r_kreg   <= w_ksat;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_a_base <= '0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_busy   <= 1'b1;
            if (w_ksat == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_klast) begin
              r_k <= '0;
              if (w_jlast) begin
                r_j      <= '0;
                r_b_addr <= '0;
                if (w_ilast) begin
                  r_i      <= '0;
                  r_a_base <= '0;
                  r_a_addr <= '0;
                  r_state  <= S_DRAIN;
                end else begin
                  r_i      <= r_i + I_BITS'(1);
                  r_a_base <= r_a_base + w_kext;
                  r_a_addr <= r_a_base + w_kext;
                end
              end else begin
                r_j      <= r_j + J_BITS'(1);
                r_b_addr <= B_ADDR_BITS'(r_j) + B_ADDR_BITS'(1);
                r_a_addr <= r_a_base;
              end
            end else begin
              r_k      <= r_k + K_BITS'(1);
              r_a_addr <= r_a_addr + A_ADDR_BITS'(1);
              r_b_addr <= r_b_addr + B_ADDR_BITS'(N);
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!i_matrices_loaded) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_a_read_addr      = r_a_addr;
  assign o_b_read_addr      = r_b_addr;
  assign o_mac_en           = r_mac_en;
  assign o_mac_first        = r_mac_first;
  assign o_mac_last         = r_mac_last;
  assign o_busy             = r_busy;
  assign o_compute_finished = r_done;

endmodule
